hub75_fb_arbiter: RTL
=====================

Name: hub75_fb_arbiter

Overview:
Time-shares the single-port frame buffer SPRAM between two masters: the row read-out engine (RO port) and the frame writer (WR port, fed by the host/SPI loader). Both masters use the same req/gnt/rel protocol. The block owns the grant FSM, the hold watchdog and the SPRAM address/data/write-enable mux. It sits between the masters and the frame buffer memory.

Parameters:
FB_AW, 13, frame buffer address width
FB_DW, 16, frame buffer data width
MAX_HOLD, 1024, maximum cycles a master may own the buffer before forced revocation (>=2)
HOLD_W, $clog2(MAX_HOLD), hold counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ro_req  in  1  read-out request level; held until granted
ro_gnt  out  1  read-out grant pulse, 1 cycle
ro_rel  in  1  read-out release pulse, 1 cycle
ro_addr  in  FB_AW  read-out address
ro_data  out  FB_DW  read data to read-out (fb_rdata passthrough)
wr_req  in  1  writer request level
wr_gnt  out  1  writer grant pulse
wr_rel  in  1  writer release pulse
wr_addr  in  FB_AW  writer address
wr_data  in  FB_DW  writer data
wr_we  in  1  writer write strobe
fb_addr  out  FB_AW  SPRAM address
fb_wdata  out  FB_DW  SPRAM write data
fb_we  out  1  SPRAM write enable
fb_rdata  in  FB_DW  SPRAM read data
owner  out  2  00 idle, 01 RO, 10 WR (registered)
timeout  out  1  sticky: a hold was revoked; cleared only by rst

Behaviour:
- Reset: FSM IDLE, owner=00, ro_gnt=wr_gnt=0, timeout=0, hold counter 0, last_owner=WR (so RO wins the first tie).
- States: IDLE, BUSY_RO, BUSY_WR.
- IDLE: when exactly one req is high, grant it. When both are high, grant the master that is not last_owner (round robin). When neither is high, stay.
- Grant edge: go to BUSY_x, set owner, pulse x_gnt for exactly 1 cycle, load last_owner, clear hold counter.
  - gnt and owner change on the same edge. The mux routes the new master during the gnt cycle.
- BUSY_x: the hold counter increments each cycle.
  - On x_rel, return to IDLE next edge with owner=00.
  - Minimum one IDLE turnaround cycle between owners. No back-to-back grant on the rel edge.
- rel from the non-owner, or rel in IDLE: ignored.
- rel in the same cycle the counter reaches MAX_HOLD-1: treat as a normal release. No timeout.
- Watchdog: counter reaches MAX_HOLD-1 without rel -> IDLE, owner=00, timeout<=1. The revoked master gets no notification beyond the loss of the mux.
- Request while owning (req high in BUSY_x from the same master): honoured only after the IDLE turnaround, under normal round-robin rules.
- Mux (combinational from registered owner):
  - RO: fb_addr=ro_addr, fb_we=0, fb_wdata=wr_data.
  - WR: fb_addr=wr_addr, fb_we=wr_we, fb_wdata=wr_data.
  - IDLE: fb_addr=0, fb_we=0.
- ro_data = fb_rdata always. SPRAM read latency of 1 cycle is the master's concern.
- wr_we while not owner: never reaches fb_we.
- Reset asserted mid-ownership: immediate IDLE, fb_we drops asynchronously to 0, no gnt pulse emitted.

Test Plan:
- ro_req rises at cycle 5, wr_req low -> ro_gnt high at cycle 6 only, owner=01. With ro_addr=0x123, fb_addr=0x123 from cycle 6. ro_rel at cycle 20 -> owner=00 at 21.
- ro_req and wr_req both high from reset release -> RO granted first. After ro_rel, one IDLE cycle, then wr_gnt. Both re-request -> RO again (round robin alternates RO, WR, RO).
- WR owns, wr_we=1, wr_addr=0x0AA, wr_data=0xBEEF -> fb_we=1, fb_addr=0x0AA, fb_wdata=0xBEEF. With owner=RO, a forced wr_we=1 -> fb_we stays 0.
- MAX_HOLD=16, WR granted and never releases -> owner returns to 00 exactly 16 cycles after gnt, timeout=1 and stays 1. A pending ro_req is then granted after the IDLE cycle.
- ro_rel coinciding with the watchdog limit -> normal release, timeout stays 0. Stray wr_rel while RO owns -> no state change.
- rst pulsed while WR owns with wr_we=1 -> fb_we=0 and owner=00 without a clock edge. After reset, wr_req still high -> wr_gnt on the first edge.

Source files
------------

// File: rtl/hub75_fb_arbiter.sv
// Frame buffer SPRAM arbiter: req/gnt/rel grant FSM with round-robin tie-break,
// hold watchdog and the SPRAM address/data/write-enable mux.
module hub75_fb_arbiter #(
    parameter int unsigned FB_AW    = 13,
    parameter int unsigned FB_DW    = 16,
    parameter int unsigned MAX_HOLD = 1024,
    parameter int unsigned HOLD_W   = $clog2(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_req,
    output logic             ro_gnt,
    input  logic             ro_rel,
    input  logic [FB_AW-1:0] ro_addr,
    output logic [FB_DW-1:0] ro_data,
    input  logic             wr_req,
    output logic             wr_gnt,
    input  logic             wr_rel,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [FB_DW-1:0] wr_data,
    input  logic             wr_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [FB_DW-1:0] fb_wdata,
    output logic             fb_we,
    input  logic [FB_DW-1:0] fb_rdata,
    output logic [1:0]       owner,
    output logic             timeout
);

    // State encoding doubles as the owner output.
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_BUSY_RO = 2'b01;
    localparam logic [1:0] S_BUSY_WR = 2'b10;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              last_wr_q, last_wr_d;
    logic              ro_gnt_q, ro_gnt_d;
    logic              wr_gnt_q, wr_gnt_d;
    logic              timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        last_wr_d = last_wr_q;
        ro_gnt_d  = 1'b0;
        wr_gnt_d  = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                hold_d = '0;
                if (ro_req && (!wr_req || last_wr_q)) begin
                    state_d   = S_BUSY_RO;
                    ro_gnt_d  = 1'b1;
                    last_wr_d = 1'b0;
                end else if (wr_req) begin
                    state_d   = S_BUSY_WR;
                    wr_gnt_d  = 1'b1;
                    last_wr_d = 1'b1;
                end
            end
            S_BUSY_RO: begin
                hold_d = hold_q + HOLD_W'(1);
                // A release on the limit cycle wins over the watchdog.
                if (ro_rel) begin
                    state_d = S_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_BUSY_WR: begin
                hold_d = hold_q + HOLD_W'(1);
                if (wr_rel) begin
                    state_d = S_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            last_wr_q <= 1'b1;
            ro_gnt_q  <= 1'b0;
            wr_gnt_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            last_wr_q <= last_wr_d;
            ro_gnt_q  <= ro_gnt_d;
            wr_gnt_q  <= wr_gnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        fb_addr  = '0;
        fb_we    = 1'b0;
        fb_wdata = wr_data;
        case (state_q)
            S_BUSY_RO: fb_addr = ro_addr;
            S_BUSY_WR: begin
                fb_addr = wr_addr;
                fb_we   = wr_we;
            end
            default: ;
        endcase
    end

    assign ro_data = fb_rdata;
    assign ro_gnt  = ro_gnt_q;
    assign wr_gnt  = wr_gnt_q;
    assign owner   = state_q;
    assign timeout = timeout_q;

endmodule
